// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Multi-cycle data memory sitting on the target side of the MEM-stage
// load/store request interface. A single word/half/byte load or store is
// accepted from IDLE. The responder holds Stall for LATENCY+1 cycles and
// then pulses Done for one cycle. Byte-lane steering, read-modify-write
// store merging and load sign extension are handled here, so the pipeline
// sees the same interface as a single-cycle data memory, only slower.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (power of two)
//   LATENCY      cycles from request accept to completion (>= 1)
//
// Ports
//   Clk        in   1   pipeline clock, rising edge
//   Reset      in   1   synchronous, active-high reset
//   MemRead    in   1   load request, held stable while Stall=1
//   MemWrite   in   1   store request, held stable while Stall=1
//   LoadHalf   in   1   load size halfword
//   LoadByte   in   1   load size byte (both size flags 0 -> word)
//   StoreHalf  in   1   store size halfword
//   StoreByte  in   1   store size byte (both size flags 0 -> word)
//   Address    in   32  byte address, little-endian lanes
//   WriteData  in   32  store data; byte/half taken from the low bits
//   ReadData   out  32  sign-extended load result, valid while Done=1
//   Stall      out  1   freeze IF..MEM pipeline registers
//   Done       out  1   one-cycle completion pulse
//   AddrError  out  1   one-cycle pulse for a misaligned request
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        LoadHalf,
  input  logic        LoadByte,
  input  logic        StoreHalf,
  input  logic        StoreByte,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        AddrError
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } size_e;

  // -------------------------------------------------------------------------
  // Storage and registered state
  // -------------------------------------------------------------------------
  logic [31:0]   mem_q [DEPTH_WORDS];

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW+1:0] addr_q;     // only the bits that select word and lane
  size_e         size_q;
  logic [31:0]   wdata_q;
  logic          store_q;
  logic [31:0]   rdata_q;
  logic          done_q;
  logic          addr_err_q;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic  req;
  size_e req_size;
  logic  misaligned;
  logic  accept;

  // Address bits above the array size alias onto the same words.
  logic  unused_addr_bits;
  assign unused_addr_bits = ^Address[31:AW+2];

  assign req = MemRead | MemWrite;

  // A simultaneous read and write is a store, so the store size flags win.
  // Within one op, byte beats half beats word.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    req_size = SZ_WORD;
    if (MemWrite) begin
      if (StoreByte)      req_size = SZ_BYTE;
      else if (StoreHalf) req_size = SZ_HALF;
    end else begin
      if (LoadByte)       req_size = SZ_BYTE;
      else if (LoadHalf)  req_size = SZ_HALF;
    end
  end

  assign misaligned = ((req_size == SZ_HALF) && Address[0]) ||
                      ((req_size == SZ_WORD) && (Address[1:0] != 2'b00));

  // Nothing is accepted while Reset is high, so Stall drops in the cycle
  // that follows an abort.
  assign accept = !Reset && (state_q == ST_IDLE) && req && !misaligned;

  // Stall must rise in the accept cycle itself so that the pipeline registers
  // freeze on the very edge at which the request is latched.
  assign Stall = accept || (state_q == ST_BUSY);

  // -------------------------------------------------------------------------
  // Lane steering for the latched request
  // -------------------------------------------------------------------------
  logic [31:0] cur_word;
  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_value_d;
  logic [31:0] store_word_d;

  assign cur_word   = mem_q[addr_q[AW+1:2]];
  assign byte_shift = {addr_q[1:0], 3'b000};
  assign half_shift = {addr_q[1], 4'b0000};
  assign ld_byte    = cur_word[byte_shift +: 8];
  assign ld_half    = cur_word[half_shift +: 16];

  always_comb begin
    load_value_d = cur_word;
    case (size_q)
      SZ_BYTE: load_value_d = {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_value_d = {{16{ld_half[15]}}, ld_half};
      default: load_value_d = cur_word;
    endcase
  end

  // Read-modify-write merge: only the addressed lane(s) take new data.
  always_comb begin
    store_word_d = cur_word;
    case (size_q)
      SZ_BYTE: store_word_d[byte_shift +: 8]  = wdata_q[7:0];
      SZ_HALF: store_word_d[half_shift +: 16] = wdata_q[15:0];
      default: store_word_d = wdata_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control FSM with registered Done / AddrError / ReadData
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      size_q     <= SZ_WORD;
      wdata_q    <= '0;
      store_q    <= 1'b0;
      rdata_q    <= '0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (misaligned) begin
              addr_err_q <= 1'b1;
            end else begin
              addr_q  <= Address[AW+1:0];
              size_q  <= req_size;
              wdata_q <= WriteData;
              store_q <= MemWrite;
              cnt_q   <= CNT_INIT;
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            // ReadData only moves for loads; stores leave the last load value.
            if (!store_q) rdata_q <= load_value_d;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The store commits on the DONE->IDLE edge; a Reset on that edge drops it.
  // NOTE: the memory array has no reset; clearing it would force a
  // flop-based array and its contents are defined by software anyway.
  always_ff @(posedge Clk) begin
    if (!Reset && (state_q == ST_DONE) && store_q) begin
      mem_q[addr_q[AW+1:2]] <= store_word_d;
    end
  end

  assign ReadData  = rdata_q;
  assign Done      = done_q;
  assign AddrError = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder with DEPTH_WORDS=1024, LATENCY=2.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (or 1 time unit after driving, for the combinational Stall).
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  localparam int SZ_W  = 0;   // word
  localparam int SZ_H  = 1;   // half
  localparam int SZ_B  = 2;   // byte
  localparam int SZ_HB = 3;   // half and byte flags both set

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MemRead;
  logic        MemWrite;
  logic        LoadHalf;
  logic        LoadByte;
  logic        StoreHalf;
  logic        StoreByte;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Done;
  logic        AddrError;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  data_mem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .LoadHalf  (LoadHalf),
    .LoadByte  (LoadByte),
    .StoreHalf (StoreHalf),
    .StoreByte (StoreByte),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .Done      (Done),
    .AddrError (AddrError)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    LoadHalf  = 1'b0;
    LoadByte  = 1'b0;
    StoreHalf = 1'b0;
    StoreByte = 1'b0;
    Address   = '0;
    WriteData = '0;
  endtask

  task automatic drive(input logic rd, input logic wr, input int sz,
                       input logic [31:0] addr, input logic [31:0] wd);
    MemRead   = rd;
    MemWrite  = wr;
    LoadHalf  = rd && (sz == SZ_H || sz == SZ_HB);
    LoadByte  = rd && (sz == SZ_B || sz == SZ_HB);
    StoreHalf = wr && (sz == SZ_H || sz == SZ_HB);
    StoreByte = wr && (sz == SZ_B || sz == SZ_HB);
    Address   = addr;
    WriteData = wd;
  endtask

  // One accepted transaction: checks Stall length, Done timing and the
  // one-cycle Done pulse; returns ReadData sampled during Done.
  task automatic xact(input string tag, input logic rd, input logic wr, input int sz,
                      input logic [31:0] addr, input logic [31:0] wd,
                      output logic [31:0] rdata);
    int   stalls;
    int   edges;
    logic got;
    @(negedge Clk);
    drive(rd, wr, sz, addr, wd);
    #1;
    stalls = 0;
    edges  = 0;
    got    = 1'b0;
    rdata  = 'x;
    for (int i = 0; i < 20 && !got; i++) begin
      if (Stall) stalls++;
      @(negedge Clk);
      edges++;
      if (Done) begin
        got   = 1'b1;
        rdata = ReadData;
        check({tag, "_stall_in_done"}, 32'(Stall), 32'd0);
      end
    end
    idle_inputs();
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(LAT + 1));
    check({tag, "_done_edge"}, 32'(edges), 32'(LAT + 1));
    @(negedge Clk);
    check({tag, "_done_one_cycle"}, 32'(Done), 32'd0);
  endtask

  // A misaligned request: no Stall, AddrError pulse in the next cycle, no Done.
  task automatic misaligned(input string tag, input logic rd, input logic wr, input int sz,
                            input logic [31:0] addr, input logic [31:0] wd);
    @(negedge Clk);
    drive(rd, wr, sz, addr, wd);
    #1;
    check({tag, "_stall"}, 32'(Stall), 32'd0);
    @(negedge Clk);
    check({tag, "_addr_error"}, 32'(AddrError), 32'd1);
    check({tag, "_no_done"}, 32'(Done), 32'd0);
    check({tag, "_stall_after"}, 32'(Stall), 32'd0);
    idle_inputs();
    @(negedge Clk);
    check({tag, "_addr_error_pulse"}, 32'(AddrError), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;

    // ---------------- reset state ----------------
    idle_inputs();
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_addr_error", 32'(AddrError), 32'd0);
    check("rst_read_data", ReadData, 32'h0);
    Reset = 1'b0;

    // ---------------- 1: store word then load word ----------------
    xact("t1_st_w", 1'b0, 1'b1, SZ_W, 32'h10, 32'hDEAD_BEEF, rd);
    xact("t1_ld_w", 1'b1, 1'b0, SZ_W, 32'h10, 32'h0, rd);
    check("t1_ld_w_data", rd, 32'hDEAD_BEEF);

    // ---------------- 2: byte store merge ----------------
    xact("t2_st_w", 1'b0, 1'b1, SZ_W, 32'h10, 32'h1122_3344, rd);
    check("t2_rdata_kept_by_store", ReadData, 32'hDEAD_BEEF);
    xact("t2_st_b", 1'b0, 1'b1, SZ_B, 32'h13, 32'h1234_5680, rd);
    xact("t2_ld_w", 1'b1, 1'b0, SZ_W, 32'h10, 32'h0, rd);
    check("t2_ld_w_data", rd, 32'h8022_3344);
    xact("t2_ld_b", 1'b1, 1'b0, SZ_B, 32'h13, 32'h0, rd);
    check("t2_ld_b_data", rd, 32'hFFFF_FF80);
    check("t2_rdata_held", ReadData, 32'hFFFF_FF80);

    // ---------------- 3: half/byte loads with sign extension ----------------
    xact("t3_st_w", 1'b0, 1'b1, SZ_W, 32'h10, 32'h8001_7FFF, rd);
    xact("t3_ld_h_hi", 1'b1, 1'b0, SZ_H, 32'h12, 32'h0, rd);
    check("t3_ld_h_hi_data", rd, 32'hFFFF_8001);
    xact("t3_ld_h_lo", 1'b1, 1'b0, SZ_H, 32'h10, 32'h0, rd);
    check("t3_ld_h_lo_data", rd, 32'h0000_7FFF);
    xact("t3_ld_b1", 1'b1, 1'b0, SZ_B, 32'h11, 32'h0, rd);
    check("t3_ld_b1_data", rd, 32'h0000_007F);
    xact("t3_ld_b0", 1'b1, 1'b0, SZ_B, 32'h10, 32'h0, rd);
    check("t3_ld_b0_data", rd, 32'hFFFF_FFFF);
    xact("t3_st_h", 1'b0, 1'b1, SZ_H, 32'h12, 32'hABCD_8002, rd);
    xact("t3_ld_w", 1'b1, 1'b0, SZ_W, 32'h10, 32'h0, rd);
    check("t3_ld_w_data", rd, 32'h8002_7FFF);

    // ---------------- 4: misaligned requests ----------------
    xact("t4_st_w", 1'b0, 1'b1, SZ_W, 32'h04, 32'h0102_0304, rd);
    misaligned("t4_ld_w_06", 1'b1, 1'b0, SZ_W, 32'h06, 32'h0);
    misaligned("t4_st_w_06", 1'b0, 1'b1, SZ_W, 32'h06, 32'h9999_9999);
    misaligned("t4_st_h_11", 1'b0, 1'b1, SZ_H, 32'h11, 32'h0000_FFFF);
    xact("t4_ld_w04", 1'b1, 1'b0, SZ_W, 32'h04, 32'h0, rd);
    check("t4_ld_w04_data", rd, 32'h0102_0304);
    xact("t4_ld_w10", 1'b1, 1'b0, SZ_W, 32'h10, 32'h0, rd);
    check("t4_ld_w10_data", rd, 32'h8002_7FFF);
    // Byte flag beats half flag, so an odd address is legal.
    xact("t4_st_hb", 1'b0, 1'b1, SZ_HB, 32'h11, 32'h0000_0055, rd);
    xact("t4_ld_w10b", 1'b1, 1'b0, SZ_W, 32'h10, 32'h0, rd);
    check("t4_ld_w10b_data", rd, 32'h8002_55FF);
    xact("t4_ld_hb", 1'b1, 1'b0, SZ_HB, 32'h13, 32'h0, rd);
    check("t4_ld_hb_data", rd, 32'hFFFF_FF80);

    // ---------------- 5: read and write together is a store ----------------
    xact("t5_rw", 1'b1, 1'b1, SZ_W, 32'h20, 32'h0000_0005, rd);
    check("t5_rdata_kept", ReadData, 32'hFFFF_FF80);
    xact("t5_ld_w", 1'b1, 1'b0, SZ_W, 32'h20, 32'h0, rd);
    check("t5_ld_w_data", rd, 32'h0000_0005);

    // ---------------- 6: reset during BUSY aborts the store ----------------
    @(negedge Clk);
    drive(1'b0, 1'b1, SZ_W, 32'h10, 32'hAAAA_AAAA);
    #1;
    check("t6_stall_accept", 32'(Stall), 32'd1);
    @(negedge Clk);
    check("t6_stall_busy", 32'(Stall), 32'd1);
    Reset = 1'b1;
    idle_inputs();
    @(negedge Clk);
    check("t6_stall_after_reset", 32'(Stall), 32'd0);
    check("t6_done_after_reset", 32'(Done), 32'd0);
    check("t6_rdata_after_reset", ReadData, 32'h0);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    check("t6_no_late_done", 32'(Done), 32'd0);
    // 4*DEPTH + 0x10 aliases word 0x10, which must keep its old value.
    xact("t6_ld_alias", 1'b1, 1'b0, SZ_W, 32'(4 * DEPTH + 16), 32'h0, rd);
    check("t6_ld_alias_data", rd, 32'h8002_55FF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
